// File: rtl/crypto_sched_pkg.sv
// crypto_sched_pkg: shared types, constants and round functions for the crypto op scheduler
// Exports: op_t, state_t, PUF_STEPS, HASH_ROUNDS, HASH_IV, HASH_RK, lfsr_step(), hash_round()
package crypto_sched_pkg;
    typedef enum logic [1:0] {OP_PUF, OP_HASH, OP_LFSR, OP_RSVD} op_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int PUF_STEPS = 64;
    localparam int HASH_ROUNDS = 4;
    localparam logic [63:0] HASH_IV = 64'hA5A5A5A5A5A5A5A5;
    localparam logic [63:0] HASH_RK = 64'hC3C3C3C3C3C3C3C3;
    function automatic logic [63:0] lfsr_step(input logic [63:0] a);
        return {a[62:0], a[63] ^ a[62] ^ a[60] ^ a[59]};
    endfunction
    function automatic logic [63:0] hash_round(input logic [63:0] a, input logic [63:0] chunk, input logic [1:0] r);
        return (a ^ chunk) ^ ((a << 3) ^ (a >> 5)) ^ (HASH_RK >> (9 * r));
    endfunction
endpackage

// File: rtl/crypto_iter_core.sv
// crypto_iter_core: iterative datapath holding acc, step count and the latched operand/opcode
// Ports: clk, rst (async, active-high); load/op_in/data_in start an operation;
//        step advances one round; op is the latched opcode, nxt the post-step acc, last flags the final step
module crypto_iter_core
    import crypto_sched_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  op_t          op_in,
    input  logic [255:0] data_in,
    output op_t          op,
    output logic [63:0]  nxt,
    output logic         last
);
    logic [63:0]  acc;
    logic [6:0]   cnt;
    logic [255:0] data;
    logic [1:0]   r;
    // hash round index 4-cnt, taken mod 4 since cnt runs 4..1
    assign r = 2'd0 - cnt[1:0];
    // a reserved op runs a single dummy step that keeps acc at zero
    assign nxt = op == OP_HASH ? hash_round(acc, data[{r, 6'd0} +: 64], r) :
                 op == OP_RSVD ? acc : lfsr_step(acc);
    assign last = cnt == 7'd1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            cnt  <= '0;
            data <= '0;
            op   <= OP_PUF;
        end else if (load) begin
            op   <= op_in;
            data <= data_in;
            acc  <= op_in == OP_HASH ? HASH_IV : op_in == OP_RSVD ? 64'd0 : data_in[63:0];
            cnt  <= op_in == OP_PUF ? 7'(PUF_STEPS) : op_in == OP_HASH ? 7'(HASH_ROUNDS) : 7'd1;
        end else if (step) begin
            acc <= nxt;
            cnt <= cnt - 7'd1;
        end
    end
endmodule

// File: rtl/crypto_op_scheduler.sv
// crypto_op_scheduler: round-robin front end sharing one iterative PUF/HASH/LFSR engine
// Ports: clk, rst (async, active-high); req/req_op/req_data per requester; flush aborts a running op;
//        gnt one-hot accept pulse; busy; rsp_valid/rsp_id/rsp_data/rsp_err result; ops_done completion count
module crypto_op_scheduler
    import crypto_sched_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDW = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   req_op,
    input  logic [256*NUM_REQ-1:0] req_data,
    input  logic                   flush,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   busy,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [63:0]            rsp_data,
    output logic                   rsp_err,
    output logic [15:0]            ops_done
);
    state_t         state, state_n;
    logic [IDW-1:0] ptr, win, idx, owner;
    logic [IDW:0]   sum;
    logic           any_req, load, step, fin, last;
    op_t            core_op;
    logic [63:0]    nxt;
    assign any_req = |req;
    assign load = state == IDLE && any_req;
    assign step = state == RUN && !flush;
    assign fin = step && last;
    assign busy = state != IDLE;
    // scan downwards so the closest set bit at or after ptr is the last one written
    always_comb begin
        win = '0;
        sum = '0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IDW + 1)'(k);
            idx = sum >= (IDW + 1)'(NUM_REQ) ? IDW'(sum - (IDW + 1)'(NUM_REQ)) : IDW'(sum);
            win = req[idx] ? idx : win;
        end
    end
    always_comb begin
        state_n = state == IDLE ? (any_req ? RUN : IDLE) :
                  state == RUN  ? (flush ? IDLE : last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            owner     <= '0;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            ops_done  <= '0;
        end else begin
            gnt       <= load ? NUM_REQ'(1) << win : '0;
            rsp_valid <= fin;
            if (load) begin
                owner <= win;
                ptr   <= win == IDW'(NUM_REQ - 1) ? '0 : win + 1'b1;
            end
            if (fin) begin
                rsp_id   <= owner;
                rsp_data <= nxt;
                rsp_err  <= core_op == OP_RSVD;
                if (core_op != OP_RSVD) ops_done <= ops_done + 16'd1;
            end
        end
    end
    crypto_iter_core u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .op_in   (op_t'(req_op[{win, 1'b0} +: 2])),
        .data_in (req_data[{win, 8'd0} +: 256]),
        .op      (core_op),
        .nxt     (nxt),
        .last    (last)
    );
endmodule
